ikaopll_dac_sched: RTL and testbench

Slot sequencer and configuration front-end for the OPLL DAC datapath.
- Runs the 18-slot operator frame.
- Per slot, decodes the DAC timing strobes: DAC enable, cycle-0 marker, melody/rhythm output select, feedback/accumulate inhibit.
- Owns the melody and rhythm accumulation-volume registers, shadowed so that they take effect only on a frame boundary.
- Sits between the chip timing generator (phi1 enable) and the DAC block.

---
 rtl/ikaopll_pkg.sv | 15 +
 rtl/ikaopll_dac_sched_if.sv | 35 +++
 rtl/ikaopll_vol_shadow.sv | 35 +++
 rtl/ikaopll_dac_sched.sv | 91 +++++++++
 tb/tb_ikaopll_dac_sched.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/ikaopll_pkg.sv
// Shared constants and types for the OPLL DAC slot sequencer.
// Slot masks are indexed by slot number (bit n = slot n).
package ikaopll_pkg;

    localparam int SLOTS_PER_FRAME = 18;

    // Melody carriers present in every mode, plus the three extra melody
    // carriers that belong to rhythm channels when rhythm mode is off.
    localparam logic [17:0] MO_BASE = 18'h32320;
    localparam logic [17:0] MO_FM3  = 18'h0000B;
    localparam logic [17:0] RO_PERC = 18'h0001F;

    typedef logic signed [4:0] vol_t;

endpackage

// File: rtl/ikaopll_dac_sched_if.sv
// Handshake bundle between the timing/register front-end and the DAC scheduler.
interface ikaopll_dac_sched_if;
    import ikaopll_pkg::*;

    logic       i_phi1_NCEN_n;
    logic       i_SYNC;
    logic       i_RHYTHM_EN;
    logic       i_MOVOL_WR;
    logic       i_ROVOL_WR;
    vol_t       i_VOL_DATA;
    logic [4:0] o_SLOT;
    logic [3:0] o_PHASE;
    logic       o_CYCLE_00;
    logic       o_MO_CTRL;
    logic       o_RO_CTRL;
    logic       o_INHIBIT_FDBK;
    logic       o_DAC_EN;
    logic       o_RHYTHM_EN;
    vol_t       o_ACC_SIGNED_MOVOL;
    vol_t       o_ACC_SIGNED_ROVOL;
    logic       o_FRAME_STRB;

    modport master (
        output i_phi1_NCEN_n, i_SYNC, i_RHYTHM_EN, i_MOVOL_WR, i_ROVOL_WR, i_VOL_DATA,
        input  o_SLOT, o_PHASE, o_CYCLE_00, o_MO_CTRL, o_RO_CTRL, o_INHIBIT_FDBK,
               o_DAC_EN, o_RHYTHM_EN, o_ACC_SIGNED_MOVOL, o_ACC_SIGNED_ROVOL, o_FRAME_STRB
    );

    modport slave (
        input  i_phi1_NCEN_n, i_SYNC, i_RHYTHM_EN, i_MOVOL_WR, i_ROVOL_WR, i_VOL_DATA,
        output o_SLOT, o_PHASE, o_CYCLE_00, o_MO_CTRL, o_RO_CTRL, o_INHIBIT_FDBK,
               o_DAC_EN, o_RHYTHM_EN, o_ACC_SIGNED_MOVOL, o_ACC_SIGNED_ROVOL, o_FRAME_STRB
    );

endinterface

// File: rtl/ikaopll_vol_shadow.sv
// Volume register with a write shadow; a captured write only becomes
// visible on the next frame-boundary commit.
module ikaopll_vol_shadow
    import ikaopll_pkg::*;
#(
    parameter vol_t VOL_RESET = 5'sd8
) (
    input  logic i_EMUCLK,
    input  logic i_RST,
    input  logic commit,
    input  logic wr,
    input  vol_t data,
    output vol_t vol
);

    vol_t shadow;
    logic pending;

    // Writes are captured on every emuclk edge, independent of phi1. A write
    // landing on the commit edge stays pending for the following frame.
    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            shadow  <= VOL_RESET;
            pending <= 1'b0;
            vol     <= VOL_RESET;
        end else begin
            if (wr)
                shadow <= data;
            if (commit && pending)
                vol <= shadow;
            pending <= wr | (pending & ~commit);
        end
    end

endmodule

// File: rtl/ikaopll_dac_sched.sv
// OPLL 18-slot operator frame sequencer with DAC strobe decode and
// frame-synchronous melody/rhythm volume registers.
module ikaopll_dac_sched
    import ikaopll_pkg::*;
#(
    parameter int   SLOT_LEN     = 4,
    parameter int   DAC_EN_START = 2,
    parameter vol_t VOL_RESET    = 5'sd8
) (
    input  logic                 i_EMUCLK,
    input  logic                 i_RST,
    ikaopll_dac_sched_if.slave   bus
);

    localparam logic [3:0] PHASE_LAST = 4'(SLOT_LEN - 1);
    localparam logic [4:0] SLOT_LAST  = 5'(SLOTS_PER_FRAME - 1);
    localparam logic [3:0] DAC_PHASE  = 4'(DAC_EN_START);

    logic [4:0] slot;
    logic [3:0] phase;
    logic       rhythm;
    logic       frame_strb;
    logic       en;
    logic       frame_start;
    logic       mo;
    logic       ro;
    vol_t       movol;
    vol_t       rovol;

    assign en          = ~bus.i_phi1_NCEN_n;
    assign frame_start = en & (bus.i_SYNC | ((phase == PHASE_LAST) & (slot == SLOT_LAST)));

    // SYNC takes priority over the normal phase/slot increment.
    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            slot       <= '0;
            phase      <= '0;
            rhythm     <= 1'b0;
            frame_strb <= 1'b0;
        end else if (en) begin
            frame_strb <= frame_start;
            if (frame_start)
                rhythm <= bus.i_RHYTHM_EN;
            if (bus.i_SYNC) begin
                slot  <= '0;
                phase <= '0;
            end else if (phase == PHASE_LAST) begin
                phase <= '0;
                slot  <= (slot == SLOT_LAST) ? 5'd0 : slot + 5'd1;
            end else begin
                phase <= phase + 4'd1;
            end
        end
    end

    always_comb begin
        mo = MO_BASE[slot] | (~rhythm & MO_FM3[slot]);
        ro = rhythm & RO_PERC[slot];
    end

    ikaopll_vol_shadow #(.VOL_RESET(VOL_RESET)) u_movol (
        .i_EMUCLK (i_EMUCLK),
        .i_RST    (i_RST),
        .commit   (frame_start),
        .wr       (bus.i_MOVOL_WR),
        .data     (bus.i_VOL_DATA),
        .vol      (movol)
    );

    ikaopll_vol_shadow #(.VOL_RESET(VOL_RESET)) u_rovol (
        .i_EMUCLK (i_EMUCLK),
        .i_RST    (i_RST),
        .commit   (frame_start),
        .wr       (bus.i_ROVOL_WR),
        .data     (bus.i_VOL_DATA),
        .vol      (rovol)
    );

    assign bus.o_SLOT             = slot;
    assign bus.o_PHASE            = phase;
    assign bus.o_CYCLE_00         = (slot == 5'd0);
    assign bus.o_MO_CTRL          = mo;
    assign bus.o_RO_CTRL          = ro;
    assign bus.o_INHIBIT_FDBK     = ~(mo | ro);
    assign bus.o_DAC_EN           = (mo | ro) & (phase >= DAC_PHASE);
    assign bus.o_RHYTHM_EN        = rhythm;
    assign bus.o_ACC_SIGNED_MOVOL = movol;
    assign bus.o_ACC_SIGNED_ROVOL = rovol;
    assign bus.o_FRAME_STRB       = frame_strb;

endmodule

// File: tb/tb_ikaopll_dac_sched.sv
// Directed bench for the OPLL DAC slot sequencer: frame walk, rhythm
// switch-over, shadowed volume writes, SYNC restart and mid-frame reset.
module tb_ikaopll_dac_sched;

    logic clock;
    logic reset;
    int   vectorCount;
    int   missCount;

    ikaopll_dac_sched_if bus ();

    ikaopll_dac_sched #(
        .SLOT_LEN     (4),
        .DAC_EN_START (2),
        .VOL_RESET    (5'sd8)
    ) dut (
        .i_EMUCLK (clock),
        .i_RST    (reset),
        .bus      (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
        end
    endtask

    // Hand-written slot table for melody carriers.
    function automatic bit expectMo(input int s, input bit r);
        case (s)
            5, 8, 9, 13, 16, 17: return 1'b1;
            0, 1, 3:             return !r;
            default:             return 1'b0;
        endcase
    endfunction

    // Checks every output against the position k = slot*4 + phase in the frame.
    task automatic applyStimulus(input int k, input bit r, input bit strbExp,
                                 input logic [4:0] moVolExp, input logic [4:0] roVolExp);
        int s;
        int p;
        bit mo;
        bit ro;
        s  = k / 4;
        p  = k % 4;
        mo = expectMo(s, r);
        ro = r && (s <= 4);
        checkOutput($sformatf("slot@%0d", k),    {27'b0, bus.o_SLOT}, s);
        checkOutput($sformatf("phase@%0d", k),   {28'b0, bus.o_PHASE}, p);
        checkOutput($sformatf("cyc00@%0d", k),   {31'b0, bus.o_CYCLE_00}, (s == 0));
        checkOutput($sformatf("mo@%0d", k),      {31'b0, bus.o_MO_CTRL}, mo);
        checkOutput($sformatf("ro@%0d", k),      {31'b0, bus.o_RO_CTRL}, ro);
        checkOutput($sformatf("inhibit@%0d", k), {31'b0, bus.o_INHIBIT_FDBK}, !(mo || ro));
        checkOutput($sformatf("dacen@%0d", k),   {31'b0, bus.o_DAC_EN}, (mo || ro) && (p >= 2));
        checkOutput($sformatf("rhythm@%0d", k),  {31'b0, bus.o_RHYTHM_EN}, r);
        checkOutput($sformatf("strb@%0d", k),    {31'b0, bus.o_FRAME_STRB}, strbExp);
        checkOutput($sformatf("movol@%0d", k),   {27'b0, bus.o_ACC_SIGNED_MOVOL}, moVolExp);
        checkOutput($sformatf("rovol@%0d", k),   {27'b0, bus.o_ACC_SIGNED_ROVOL}, roVolExp);
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        vectorCount = 0;
        missCount   = 0;
        reset       = 1'b1;
        bus.i_phi1_NCEN_n = 1'b0;
        bus.i_SYNC        = 1'b0;
        bus.i_RHYTHM_EN   = 1'b0;
        bus.i_MOVOL_WR    = 1'b0;
        bus.i_ROVOL_WR    = 1'b0;
        bus.i_VOL_DATA    = '0;
        repeat (2) @(negedge clock);
        applyStimulus(0, 0, 0, 5'd8, 5'd8);
        reset = 1'b0;

        // Frame A: plain melody decode, with a short phi1 stall at k=5.
        for (int k = 0; k < 72; k++) begin
            applyStimulus(k, 0, 0, 5'd8, 5'd8);
            if (k == 5) begin
                bus.i_phi1_NCEN_n = 1'b1;
                repeat (3) tick();
                applyStimulus(5, 0, 0, 5'd8, 5'd8);
                bus.i_phi1_NCEN_n = 1'b0;
            end
            tick();
        end

        // Frame B: rhythm request at slot 7, two MOVOL writes at slots 10 and 12.
        for (int k = 0; k < 72; k++) begin
            applyStimulus(k, 0, (k == 0), 5'd8, 5'd8);
            if (k == 28) bus.i_RHYTHM_EN = 1'b1;
            if (k == 40) begin bus.i_MOVOL_WR = 1'b1; bus.i_VOL_DATA = 5'h1D; end
            if (k == 48) begin bus.i_MOVOL_WR = 1'b1; bus.i_VOL_DATA = 5'h06; end
            tick();
            bus.i_MOVOL_WR = 1'b0;
        end

        // Frame C: rhythm decode, ROVOL=-16 pending, SYNC at slot 9 phase 1.
        for (int k = 0; k <= 37; k++) begin
            applyStimulus(k, 1, (k == 0), 5'h06, 5'd8);
            if (k == 20) begin bus.i_ROVOL_WR = 1'b1; bus.i_VOL_DATA = 5'h10; end
            if (k == 37) bus.i_SYNC = 1'b1;
            tick();
            bus.i_ROVOL_WR = 1'b0;
            bus.i_SYNC     = 1'b0;
        end

        // Frame D: restarted by SYNC; MOVOL write pending when reset hits at slot 15.
        for (int k = 0; k <= 60; k++) begin
            applyStimulus(k, 1, (k == 0), 5'h06, 5'h10);
            if (k == 56) begin bus.i_MOVOL_WR = 1'b1; bus.i_VOL_DATA = 5'h02; end
            if (k < 60) tick();
            bus.i_MOVOL_WR = 1'b0;
        end
        #2 reset = 1'b1;
        #1 applyStimulus(0, 0, 0, 5'd8, 5'd8);
        @(negedge clock);
        reset = 1'b0;

        // Frame E: latch still 0 after reset; both volumes written on the frame-start edge.
        for (int k = 0; k < 72; k++) begin
            applyStimulus(k, 0, 0, 5'd8, 5'd8);
            if (k == 71) begin
                bus.i_MOVOL_WR = 1'b1;
                bus.i_ROVOL_WR = 1'b1;
                bus.i_VOL_DATA = 5'h03;
            end
            tick();
            bus.i_MOVOL_WR = 1'b0;
            bus.i_ROVOL_WR = 1'b0;
        end

        // Frame F: discarded write never shows, same-edge write still deferred.
        for (int k = 0; k < 72; k++) begin
            applyStimulus(k, 1, (k == 0), 5'd8, 5'd8);
            tick();
        end
        applyStimulus(0, 1, 1, 5'h03, 5'h03);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
